// File: rtl/ambx_core.sv
// Accumulator micro-core. The instruction memory is combinational and indexed by pc.
// Data memory is reached through a req/ready handshake, and a small hardware stack
// holds CALL return addresses.
module ambx_core #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] operand,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] accum,
  output logic              carry,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] ddatain,
  input  logic              dmem_ready,
  output logic              halted,
  output logic              err
);

  // sp counts 0..STACK_DEPTH, so it needs one more bit than the entry index.
  localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = $clog2(STACK_DEPTH);

  localparam logic [3:0] OpLd  = 4'h0, OpAdd = 4'h1, OpSub  = 4'h2, OpAnd = 4'h3;
  localparam logic [3:0] OpOr  = 4'h4, OpXor = 4'h5, OpLdi  = 4'h6, OpSt  = 4'h7;
  localparam logic [3:0] OpBez = 4'h8, OpBnz = 4'h9, OpJmp  = 4'hA, OpCall = 4'hB;
  localparam logic [3:0] OpRet = 4'hC, OpBc  = 4'hD, OpNop  = 4'hE;

  typedef enum logic [1:0] {StExec, StMem, StHalt} state_e;

  state_e            state_q;
  logic [3:0]        op_q;
  logic [SpW-1:0]    sp_q;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [SpW-1:0]    sp_dec;
  logic              stack_full;
  logic              stack_empty;
  logic              push_en;
  logic [ADDR_W-1:0] stack_top;

  assign pc_inc      = pc + ADDR_W'(1);
  assign sp_dec      = sp_q - SpW'(1);
  assign stack_full  = (sp_q == SpW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign push_en     = (state_q == StExec) && (opcode == OpCall) && !stack_full;
  assign stack_top   = stack_q[sp_dec[IdxW-1:0]];
  // accum is frozen while a request is outstanding, so it doubles as write data.
  assign dmem_wdata  = accum;

  // Return-stack storage: deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[sp_q[IdxW-1:0]] <= pc_inc;
  end

  // Core FSM with all architectural state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StExec;
      op_q      <= 4'h0;
      sp_q      <= '0;
      pc        <= '0;
      accum     <= '0;
      carry     <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      dmem_addr <= '0;
      halted    <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state_q)
        StExec: begin
          case (opcode)
            OpLd, OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSt: begin
              op_q      <= opcode;
              dmem_addr <= operand;
              dmem_req  <= 1'b1;
              dmem_we   <= (opcode == OpSt);
              state_q   <= StMem;
            end
            OpLdi: begin
              accum <= DATA_W'(operand);
              pc    <= pc_inc;
            end
            OpBez:  pc <= (accum == '0) ? operand : pc_inc;
            OpBnz:  pc <= (accum != '0) ? operand : pc_inc;
            OpBc:   pc <= carry ? operand : pc_inc;
            OpJmp:  pc <= operand;
            OpNop:  pc <= pc_inc;
            OpCall: begin
              if (stack_full) begin
                err     <= 1'b1;
                halted  <= 1'b1;
                state_q <= StHalt;
              end else begin
                sp_q <= sp_q + SpW'(1);
                pc   <= operand;
              end
            end
            OpRet: begin
              if (stack_empty) begin
                err     <= 1'b1;
                halted  <= 1'b1;
                state_q <= StHalt;
              end else begin
                sp_q <= sp_dec;
                pc   <= stack_top;
              end
            end
            default: begin
              halted  <= 1'b1;
              state_q <= StHalt;
            end
          endcase
        end
        StMem: begin
          if (dmem_ready) begin
            case (op_q)
              OpLd:  accum <= ddatain;
              OpAdd: {carry, accum} <= {1'b0, accum} + {1'b0, ddatain};
              OpSub: begin
                accum <= accum - ddatain;
                carry <= (accum < ddatain);
              end
              OpAnd: accum <= accum & ddatain;
              OpOr:  accum <= accum | ddatain;
              OpXor: accum <= accum ^ ddatain;
              default: ;
            endcase
            pc       <= pc_inc;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state_q  <= StExec;
          end
        end
        StHalt: ;
        default: state_q <= StHalt;
      endcase
    end
  end

endmodule

// File: tb/tb_ambx_core.sv
// Directed bench for ambx_core: small programs in a model instruction ROM, with a
// data-memory responder whose ready latency can be set.
module tb_ambx_core;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic [7:0] operand;
  logic [7:0] pc;
  logic [7:0] accum;
  logic       carry;
  logic       dmem_req;
  logic       dmem_we;
  logic [7:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic [7:0] ddatain;
  logic       dmem_ready;
  logic       halted;
  logic       err;

  logic [3:0] imem_op  [256];
  logic [7:0] imem_arg [256];
  logic [7:0] dmem     [256];

  int   lat;
  int   cnt;
  logic force_ready;
  int   n_vec;
  int   n_err;
  int   n_req;

  ambx_core #(.DATA_W(8), .ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .operand    (operand),
    .pc         (pc),
    .accum      (accum),
    .carry      (carry),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .ddatain    (ddatain),
    .dmem_ready (dmem_ready),
    .halted     (halted),
    .err        (err)
  );

  assign opcode     = imem_op[pc];
  assign operand    = imem_arg[pc];
  assign dmem_ready = force_ready || (dmem_req && (cnt >= lat));
  assign ddatain    = force_ready ? 8'hAA : dmem[dmem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count how long the current request has been waiting.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= 0;
    else if (!dmem_req || dmem_ready) cnt <= 0;
    else                           cnt <= cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) begin
      imem_op[i]  = 4'hF;
      imem_arg[i] = 8'h00;
    end
  endtask

  task automatic put(input logic [7:0] a, input logic [3:0] op, input logic [7:0] arg);
    imem_op[a]  = op;
    imem_arg[a] = arg;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    lat         = 0;
    force_ready = 1'b0;
    rst_n       = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    dmem[8'h10] = 8'hFE;
    dmem[8'h11] = 8'h04;
    dmem[8'h12] = 8'h0F;

    // Arithmetic, branches and a stalled store.
    clear_imem();
    put(8'h00, 4'h6, 8'h05);  // LDI 5
    put(8'h01, 4'h1, 8'h10);  // ADD @10
    put(8'h02, 4'hD, 8'h20);  // BC 20
    put(8'h20, 4'h2, 8'h11);  // SUB @11
    put(8'h21, 4'h9, 8'h28);  // BNZ 28
    put(8'h28, 4'h5, 8'h12);  // XOR @12
    put(8'h29, 4'h7, 8'h30);  // ST @30
    do_reset();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_accum", 32'(accum), 32'h0);
    check("rst_carry", 32'(carry), 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    tick();
    check("ldi_accum", 32'(accum), 32'h05);
    check("ldi_pc", 32'(pc), 32'h01);
    tick();
    check("add_req", 32'(dmem_req), 32'h1);
    check("add_we", 32'(dmem_we), 32'h0);
    check("add_addr", 32'(dmem_addr), 32'h10);
    check("add_pc_hold", 32'(pc), 32'h01);
    tick();
    check("add_accum", 32'(accum), 32'h03);
    check("add_carry", 32'(carry), 32'h1);
    check("add_pc", 32'(pc), 32'h02);
    check("add_req_drop", 32'(dmem_req), 32'h0);
    tick();
    check("bc_pc", 32'(pc), 32'h20);
    tick();
    tick();
    check("sub_accum", 32'(accum), 32'hFF);
    check("sub_carry", 32'(carry), 32'h1);
    tick();
    check("bnz_pc", 32'(pc), 32'h28);
    tick();
    tick();
    check("xor_accum", 32'(accum), 32'hF0);
    check("xor_carry", 32'(carry), 32'h1);
    lat = 3;
    tick();
    n_req = 0;
    for (int i = 0; i < 20 && dmem_req; i++) begin
      n_req++;
      check("st_we", 32'(dmem_we), 32'h1);
      check("st_addr", 32'(dmem_addr), 32'h30);
      check("st_wdata", 32'(dmem_wdata), 32'hF0);
      if (!dmem_ready) check("st_pc_hold", 32'(pc), 32'h29);
      tick();
    end
    check("st_req_cycles", 32'(n_req), 32'd4);
    check("st_pc", 32'(pc), 32'h2A);
    check("st_accum", 32'(accum), 32'hF0);
    lat = 0;
    tick();
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_pc", 32'(pc), 32'h2A);
    tick();
    tick();
    check("halt_pc_frozen", 32'(pc), 32'h2A);
    check("halt_req", 32'(dmem_req), 32'h0);
    check("halt_err", 32'(err), 32'h0);

    // Stack overflow on the fifth nested CALL.
    clear_imem();
    put(8'h00, 4'hB, 8'h10);
    put(8'h10, 4'hB, 8'h20);
    put(8'h20, 4'hB, 8'h30);
    put(8'h30, 4'hB, 8'h40);
    put(8'h40, 4'hB, 8'h50);
    do_reset();
    tick();
    check("call1_pc", 32'(pc), 32'h10);
    tick();
    tick();
    tick();
    check("call4_pc", 32'(pc), 32'h40);
    tick();
    check("ovf_err", 32'(err), 32'h1);
    check("ovf_halted", 32'(halted), 32'h1);
    check("ovf_pc", 32'(pc), 32'h40);
    tick();
    check("ovf_pc_frozen", 32'(pc), 32'h40);

    // Four CALLs unwound by four RETs, then pc wrap at 0xFF.
    put(8'h40, 4'hC, 8'h00);
    put(8'h31, 4'hC, 8'h00);
    put(8'h21, 4'hC, 8'h00);
    put(8'h11, 4'hC, 8'h00);
    put(8'h01, 4'hA, 8'hFF);
    put(8'hFF, 4'hE, 8'h00);
    do_reset();
    check("rerun_err", 32'(err), 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("rerun_pc", 32'(pc), 32'h40);
    tick();
    check("ret1_pc", 32'(pc), 32'h31);
    tick();
    check("ret2_pc", 32'(pc), 32'h21);
    tick();
    check("ret3_pc", 32'(pc), 32'h11);
    tick();
    check("ret4_pc", 32'(pc), 32'h01);
    tick();
    check("jmp_pc", 32'(pc), 32'hFF);
    tick();
    check("wrap_pc", 32'(pc), 32'h00);
    check("wrap_err", 32'(err), 32'h0);
    check("wrap_halted", 32'(halted), 32'h0);

    // RET with an empty stack.
    clear_imem();
    put(8'h00, 4'hC, 8'h00);
    do_reset();
    tick();
    check("uflow_err", 32'(err), 32'h1);
    check("uflow_halted", 32'(halted), 32'h1);
    check("uflow_pc", 32'(pc), 32'h00);

    // Asynchronous reset in the middle of a memory access.
    clear_imem();
    put(8'h00, 4'h6, 8'h07);
    put(8'h01, 4'h0, 8'h10);
    lat = 100;
    do_reset();
    tick();
    check("pre_accum", 32'(accum), 32'h07);
    tick();
    check("pre_req", 32'(dmem_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc", 32'(pc), 32'h0);
    check("arst_accum", 32'(accum), 32'h0);
    check("arst_req", 32'(dmem_req), 32'h0);
    check("arst_we", 32'(dmem_we), 32'h0);
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    check("arst_late_pc", 32'(pc), 32'h0);
    check("arst_late_accum", 32'(accum), 32'h0);
    put(8'h00, 4'hE, 8'h00);
    rst_n = 1'b1;
    force_ready = 1'b1;
    tick();
    force_ready = 1'b0;
    check("post_pc", 32'(pc), 32'h01);
    check("post_accum", 32'(accum), 32'h00);
    check("post_req", 32'(dmem_req), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ambx_core.md
AMBX_CORE -- requirements
Module: ambx_core

Interface
REQ-001 Parameter DATA_W, default 8: accumulator and data-memory data width.
REQ-002 Parameter ADDR_W, default 8: width of pc, operand and memory addresses.
REQ-003 Parameter STACK_DEPTH, default 4: return-stack entries; legal range is 2..16.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 opcode  in  4  instruction opcode at address pc (combinational instruction memory).
REQ-007 operand  in  ADDR_W  instruction operand at address pc.
REQ-008 pc  out  ADDR_W  program counter, registered.
REQ-009 accum  out  DATA_W  accumulator, registered.
REQ-010 carry  out  1  carry/borrow flag, registered.
REQ-011 dmem_req  out  1  data-memory request; held high until dmem_ready is seen.
REQ-012 dmem_we  out  1  write qualifier; valid only while dmem_req is high.
REQ-013 dmem_addr  out  ADDR_W  data address; equals the latched operand while dmem_req is high.
REQ-014 dmem_wdata  out  DATA_W  equals accum while dmem_req is high.
REQ-015 ddatain  in  DATA_W  read data; sampled only in the cycle where dmem_ready is high.
REQ-016 dmem_ready  in  1  completes the pending request; ignored while dmem_req is low.
REQ-017 halted  out  1  core is in the HALT state.
REQ-018 err  out  1  sticky stack-fault flag.

Function
REQ-019 Opcodes: 0 LD, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDI, 7 ST, 8 BEZ, 9 BNZ, A JMP, B CALL, C RET, D BC, E NOP, F HALT.
REQ-020 FSM states are EXEC, MEM and HALT; reset state is EXEC.
REQ-021 In EXEC, opcodes 0-5 and 7 latch operand, assert dmem_req (dmem_we=1 only for ST) and move to MEM; pc does not change.
REQ-022 In MEM, while dmem_ready=0 all state holds, with no timeout.
REQ-023 In MEM, when dmem_ready=1 the core completes the operation, sets pc<=pc+1, drops dmem_req next cycle and returns to EXEC; minimum latency is 2 cycles per memory instruction.
REQ-024 On completion, LD sets accum<=ddatain; AND/OR/XOR set accum<=accum op ddatain; carry is unchanged.
REQ-025 On completion, ADD sets {carry,accum}<=accum+ddatain, with DATA_W+1-bit result.
REQ-026 On completion, SUB sets accum<=accum-ddatain modulo 2^DATA_W and carry<=(accum<ddatain) unsigned.
REQ-027 On completion, ST leaves accum and carry unchanged.
REQ-028 Opcodes 6 and 8-E complete in EXEC in one cycle with no dmem_req.
REQ-029 LDI sets accum<=operand, zero-extended or truncated to DATA_W; pc<=pc+1.
REQ-030 BEZ, BNZ and BC jump (pc<=operand) when accum==0, accum!=0 or carry==1 respectively; otherwise pc<=pc+1.
REQ-031 JMP sets pc<=operand unconditionally.
REQ-032 NOP sets pc<=pc+1.
REQ-033 CALL pushes pc+1 (mod 2^ADDR_W) onto the return stack and sets pc<=operand.
REQ-034 RET pops the top of the return stack into pc.
REQ-035 A CALL with the stack already holding STACK_DEPTH entries does not push, sets err<=1 and enters HALT; pc is unchanged.
REQ-036 A RET with an empty stack sets err<=1 and enters HALT; pc is unchanged.
REQ-037 HALT (opcode F) enters HALT with pc unchanged.
REQ-038 The HALT state is left only by reset; pc, accum, carry and the stack freeze; dmem_req=0; halted=1.
REQ-039 pc+1 wraps from 2^ADDR_W-1 to 0 without fault.
REQ-040 The stack pointer is ADDR-independent, counts 0..STACK_DEPTH, and stack contents are not reset.

Reset
REQ-041 When rst_n=0, regardless of state (including mid-MEM), the next values are: pc=0, accum=0, carry=0, err=0, halted=0, dmem_req=0, dmem_we=0, stack pointer=0, state EXEC.
REQ-042 Reset release takes effect on the first rising clk edge with rst_n=1; an outstanding memory request is abandoned and a late dmem_ready is ignored.

Verification
REQ-043 Program LDI 0x05, ADD @0x10 (mem=0xFE), BC 0x20 -> accum=0x03, carry=1, pc=0x20.
REQ-044 SUB @0x11 with accum=0x03, mem=0x04 -> accum=0xFF, carry=1; BNZ taken.
REQ-045 ST @0x30 with dmem_ready held low 3 cycles -> dmem_req high 4 cycles, dmem_we=1, dmem_addr=0x30, wdata=accum, pc advances once.
REQ-046 With STACK_DEPTH=4, five nested CALLs -> the 5th sets err=1 and halted=1, pc equals that CALL's address; four RETs after reset and re-run return correctly.
REQ-047 RET at reset (empty stack) -> err=1, halted=1, pc=0.
REQ-048 Assert rst_n low while in MEM with dmem_req high -> all outputs return to their reset values asynchronously, and a following dmem_ready pulse causes no change.
